// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: executes loads and stores over a byte-wide RAM
// port (little-endian, one byte per handshake), stalls upstream while busy and
// presents the write-back triple to MEM/WB. Non-memory ops pass straight through.

`ifndef MEM_ACCESS_UNIT_DEFS
`define MEM_ACCESS_UNIT_DEFS
`define REG_WIDTH    5
`define DATA_WIDTH   32
`define ALU_OP_WIDTH 8
`define ALU_ADD      8'h01
`define ALU_LB       8'h20
`define ALU_LH       8'h21
`define ALU_LW       8'h22
`define ALU_LBU      8'h24
`define ALU_LHU      8'h25
`define ALU_SB       8'h28
`define ALU_SH       8'h29
`define ALU_SW       8'h2A
`endif

module mem_access_unit #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [`REG_WIDTH-1:0]    mem_rd,
  input  logic                     mem_rd_op,
  input  logic [`DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [`ALU_OP_WIDTH-1:0] mem_aluop,
  input  logic [`DATA_WIDTH-1:0]   mem_mem_addr,
  input  logic [`DATA_WIDTH-1:0]   mem_mem_wdata,
  output logic                     ram_req,
  output logic                     ram_we,
  output logic [`DATA_WIDTH-1:0]   ram_addr,
  output logic [7:0]               ram_wdata,
  input  logic [7:0]               ram_rdata,
  input  logic                     ram_ready,
  output logic                     stall_req,
  output logic                     mem_err,
  output logic [`REG_WIDTH-1:0]    wb_rd,
  output logic                     wb_rd_op,
  output logic [`DATA_WIDTH-1:0]   wb_rd_data
);

  localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state_reg;
  logic [`DATA_WIDTH-1:0] addr_reg;
  logic [`DATA_WIDTH-1:0] wdata_reg;
  logic [`DATA_WIDTH-1:0] data_reg;
  logic [2:0]             size_reg;
  logic [2:0]             k_reg;
  logic                   sign_reg;
  logic                   we_reg;
  logic                   err_reg;
  logic [WW-1:0]          wait_reg;

  logic                   is_mem;
  logic [2:0]             dec_size;
  logic                   dec_sign;
  logic                   dec_we;
  logic [`DATA_WIDTH-1:0] load_value;

  // Decode the EX/MEM op into transfer size, sign-extension and direction
  always_comb begin
    is_mem   = 1'b1;
    dec_size = 3'd4;
    dec_sign = 1'b0;
    dec_we   = 1'b0;
    case (mem_aluop)
      `ALU_LB:  begin dec_size = 3'd1; dec_sign = 1'b1; end
      `ALU_LH:  begin dec_size = 3'd2; dec_sign = 1'b1; end
      `ALU_LW:  dec_size = 3'd4;
      `ALU_LBU: dec_size = 3'd1;
      `ALU_LHU: dec_size = 3'd2;
      `ALU_SB:  begin dec_size = 3'd1; dec_we = 1'b1; end
      `ALU_SH:  begin dec_size = 3'd2; dec_we = 1'b1; end
      `ALU_SW:  begin dec_size = 3'd4; dec_we = 1'b1; end
      default:  is_mem = 1'b0;
    endcase
  end

  // Access FSM: latch the op in IDLE, move bytes in ACCESS, one DONE cycle
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      data_reg  <= '0;
      size_reg  <= '0;
      k_reg     <= '0;
      sign_reg  <= 1'b0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      wait_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_mem) begin
            addr_reg  <= mem_mem_addr;
            wdata_reg <= mem_mem_wdata;
            size_reg  <= dec_size;
            sign_reg  <= dec_sign;
            we_reg    <= dec_we;
            k_reg     <= '0;
            wait_reg  <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          // A byte completing on the same edge as the timeout wins
          if (ram_ready) begin
            if (!we_reg) data_reg[{k_reg[1:0], 3'b000} +: 8] <= ram_rdata;
            k_reg    <= k_reg + 3'd1;
            wait_reg <= '0;
            if (k_reg + 3'd1 == size_reg) state_reg <= DONE;
          end else if (wait_reg == WAIT_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Extend the assembled bytes according to size and signedness
  always_comb begin
    case (size_reg)
      3'd1:    load_value = sign_reg ? {{24{data_reg[7]}}, data_reg[7:0]}
                                     : {24'd0, data_reg[7:0]};
      3'd2:    load_value = sign_reg ? {{16{data_reg[15]}}, data_reg[15:0]}
                                     : {16'd0, data_reg[15:0]};
      default: load_value = data_reg;
    endcase
  end

  // Output decode; everything is held at zero while reset is asserted
  always_comb begin
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    stall_req  = 1'b0;
    mem_err    = 1'b0;
    wb_rd      = '0;
    wb_rd_op   = 1'b0;
    wb_rd_data = '0;
    if (RST) begin
      case (state_reg)
        IDLE: begin
          if (is_mem) begin
            stall_req = 1'b1;
          end else begin
            wb_rd      = mem_rd;
            wb_rd_op   = mem_rd_op;
            wb_rd_data = mem_rd_data;
          end
        end
        ACCESS: begin
          ram_req   = 1'b1;
          ram_we    = we_reg;
          ram_addr  = addr_reg + {29'd0, k_reg};
          ram_wdata = wdata_reg[{k_reg[1:0], 3'b000} +: 8];
          stall_req = 1'b1;
        end
        DONE: begin
          wb_rd   = mem_rd;
          mem_err = err_reg;
          if (!err_reg) begin
            wb_rd_op = mem_rd_op;
            if (!we_reg) wb_rd_data = load_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a RAM model with programmable
// ready delay, a transfer scoreboard checked per byte and a write-back
// scoreboard checked in the DONE cycle.

`ifndef MEM_ACCESS_UNIT_DEFS
`define MEM_ACCESS_UNIT_DEFS
`define REG_WIDTH    5
`define DATA_WIDTH   32
`define ALU_OP_WIDTH 8
`define ALU_ADD      8'h01
`define ALU_LB       8'h20
`define ALU_LH       8'h21
`define ALU_LW       8'h22
`define ALU_LBU      8'h24
`define ALU_LHU      8'h25
`define ALU_SB       8'h28
`define ALU_SH       8'h29
`define ALU_SW       8'h2A
`endif

module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        mem_rd_op = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic [7:0]  mem_aluop = `ALU_ADD;
  logic [31:0] mem_mem_addr = '0;
  logic [31:0] mem_mem_wdata = '0;
  logic        ram_req, ram_we, ram_ready, stall_req, mem_err, wb_rd_op;
  logic [31:0] ram_addr, wb_rd_data;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [4:0]  wb_rd;

  mem_access_unit #(.WAIT_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .mem_rd(mem_rd), .mem_rd_op(mem_rd_op), .mem_rd_data(mem_rd_data),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_mem_wdata(mem_mem_wdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stall_req(stall_req), .mem_err(mem_err),
    .wb_rd(wb_rd), .wb_rd_op(wb_rd_op), .wb_rd_data(wb_rd_data)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } xfer_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_op;
    logic [31:0] data;
    logic        err;
  } wb_t;

  xfer_t xq[$];
  wb_t   wq[$];
  int    total = 0;
  int    bad = 0;
  int    delay = 0;
  bit    stuck = 1'b0;
  bit    mon_en = 1'b0;
  int    wait_ctr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // RAM model: ready after 'delay' low cycles per byte, never when stuck
  assign ram_ready = !stuck && (wait_ctr >= delay);

  always @(posedge CLK) begin
    if (!ram_req || ram_ready) wait_ctr <= 0;
    else wait_ctr <= wait_ctr + 1;
  end

  // Transfer monitor: every requested byte must match the scoreboard head
  always @(negedge CLK) begin
    if (mon_en && ram_req) begin
      if (xq.size() == 0) begin
        check("xfer_extra", {31'd0, ram_req}, 32'd0);
      end else begin
        check("xfer_addr", ram_addr, xq[0].addr);
        check("xfer_we", {31'd0, ram_we}, {31'd0, xq[0].we});
        if (xq[0].we) check("xfer_wdata", {24'd0, ram_wdata}, {24'd0, xq[0].wdata});
        ram_rdata <= xq[0].we ? 8'h00 : xq[0].rdata;
        if (ram_ready) void'(xq.pop_front());
      end
    end
  end

  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rbytes,
                        input logic [4:0] rd, input logic rd_op, input int n, input bit we,
                        input int dly, input bit stk, input logic [31:0] exp_data,
                        input int exp_stall);
    int  stalls;
    bit  done;
    wb_t e;
    for (int i = 0; i < (stk ? 1 : n); i++)
      xq.push_back('{addr + 32'(i), we, wdata[8*i +: 8], rbytes[8*i +: 8]});
    wq.push_back('{rd, stk ? 1'b0 : rd_op, stk ? 32'd0 : exp_data, stk});
    delay = dly;
    stuck = stk;
    mem_aluop = op;
    mem_mem_addr = addr;
    mem_mem_wdata = wdata;
    mem_rd = rd;
    mem_rd_op = rd_op;
    mem_rd_data = 32'hCAFE0000;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      if (stall_req) stalls++;
      else done = 1'b1;
    end
    if (!done) check($sformatf("%s.done_seen", name), {31'd0, stall_req}, 32'd0);
    e = wq.pop_front();
    check($sformatf("%s.wb_rd", name), {27'd0, wb_rd}, {27'd0, e.rd});
    check($sformatf("%s.wb_rd_op", name), {31'd0, wb_rd_op}, {31'd0, e.rd_op});
    check($sformatf("%s.wb_rd_data", name), wb_rd_data, e.data);
    check($sformatf("%s.mem_err", name), {31'd0, mem_err}, {31'd0, e.err});
    check($sformatf("%s.done_req", name), {31'd0, ram_req}, 32'd0);
    check($sformatf("%s.stalls", name), 32'(stalls), 32'(exp_stall));
    if (stk) xq.delete();
    check($sformatf("%s.xfers_left", name), 32'(xq.size()), 32'd0);
    $display("op %s addr=%h data=%h stalls=%0d err=%0d", name, addr, wb_rd_data, stalls, mem_err);
    @(posedge CLK);
    #1;
    mem_aluop = `ALU_ADD;
    mem_rd_op = 1'b0;
    stuck = 1'b0;
    delay = 0;
  endtask

  initial begin
    // Reset held with a load presented: all outputs must be zero
    RST = 1'b0;
    mem_aluop = `ALU_LW;
    mem_mem_addr = 32'h40;
    mem_rd = 5'd3;
    mem_rd_op = 1'b1;
    mem_rd_data = 32'h5555AAAA;
    repeat (2) begin
      @(negedge CLK);
      check("rst.ram_req", {31'd0, ram_req}, 32'd0);
      check("rst.stall", {31'd0, stall_req}, 32'd0);
      check("rst.wb_rd_op", {31'd0, wb_rd_op}, 32'd0);
      check("rst.wb_rd_data", wb_rd_data, 32'd0);
      check("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("rel.idle_req", {31'd0, ram_req}, 32'd0);
    check("rel.idle_stall", {31'd0, stall_req}, 32'd1);
    @(negedge CLK);
    check("rel.access_req", {31'd0, ram_req}, 32'd1);
    check("rel.addr0", ram_addr, 32'h40);
    @(negedge CLK);
    check("rel.addr1", ram_addr, 32'h41);
    // Reset in the middle of the access abandons it
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("midrst.req", {31'd0, ram_req}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    mem_aluop = `ALU_ADD;
    mem_rd = 5'd5;
    mem_rd_op = 1'b1;
    mem_rd_data = 32'h1234;
    @(negedge CLK);
    check("pass.ram_req", {31'd0, ram_req}, 32'd0);
    check("pass.stall", {31'd0, stall_req}, 32'd0);
    check("pass.wb_rd", {27'd0, wb_rd}, 32'd5);
    check("pass.wb_rd_op", {31'd0, wb_rd_op}, 32'd1);
    check("pass.wb_rd_data", wb_rd_data, 32'h1234);
    $display("op pass add rd=5 data=%h", wb_rd_data);
    @(posedge CLK);
    #1;
    mem_rd = 5'd31;
    mem_rd_op = 1'b0;
    mem_rd_data = 32'hFFFFFFFF;
    @(negedge CLK);
    check("pass2.wb_rd", {27'd0, wb_rd}, 32'd31);
    check("pass2.wb_rd_op", {31'd0, wb_rd_op}, 32'd0);
    check("pass2.wb_rd_data", wb_rd_data, 32'hFFFFFFFF);
    $display("op pass add rd=31 data=%h", wb_rd_data);
    @(posedge CLK);
    #1;
    mon_en = 1'b1;

    //     name     op        addr          wdata         rbytes        rd    op    n  we dly stk exp_data      stall
    run_op("lw",    `ALU_LW,  32'h100,      32'h0,        32'h44332211, 5'd7, 1'b1, 4, 0, 0, 0, 32'h44332211, 5);
    run_op("lb",    `ALU_LB,  32'h7,        32'h0,        32'h00000080, 5'd8, 1'b1, 1, 0, 0, 0, 32'hFFFFFF80, 2);
    run_op("lbu",   `ALU_LBU, 32'h7,        32'h0,        32'h00000080, 5'd9, 1'b1, 1, 0, 0, 0, 32'h00000080, 2);
    run_op("lh",    `ALU_LH,  32'hFFFFFFFF, 32'h0,        32'h00009234, 5'd10, 1'b1, 2, 0, 0, 0, 32'hFFFF9234, 3);
    run_op("lhu",   `ALU_LHU, 32'h10,       32'h0,        32'h00008501, 5'd11, 1'b1, 2, 0, 0, 0, 32'h00008501, 3);
    run_op("sw",    `ALU_SW,  32'h20,       32'hDEADBEEF, 32'h0,        5'd0, 1'b0, 4, 1, 3, 0, 32'h0,        17);
    run_op("sb",    `ALU_SB,  32'h30,       32'h123456AB, 32'h0,        5'd0, 1'b0, 1, 1, 0, 0, 32'h0,        2);
    run_op("sh",    `ALU_SH,  32'h31,       32'h00005566, 32'h0,        5'd0, 1'b0, 2, 1, 1, 0, 32'h0,        5);
    run_op("lw_to", `ALU_LW,  32'h200,      32'h0,        32'h0,        5'd12, 1'b1, 4, 0, 0, 1, 32'h0,        5);
    run_op("lw_d2", `ALU_LW,  32'h300,      32'h0,        32'hA1B2C3D4, 5'd13, 1'b1, 4, 0, 2, 0, 32'hA1B2C3D4, 13);

    // Back in IDLE with a non-memory op: no further requests
    @(negedge CLK);
    check("end.ram_req", {31'd0, ram_req}, 32'd0);
    check("end.stall", {31'd0, stall_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
